sort_step_controller: RTL and testbench
=======================================

Name: sort_step_controller

Overview:
Sequencer for the bar-sort visualisation datapath. It owns run/pause, paces automatic sort steps with a delay timer, and issues single-step requests to the sort engine over a req/ack handshake. It snapshots bar heights plus engine indices before every step into a LIFO history, which the engine uses to undo steps. It sits between the debounced button pulses and the sort engine; the OLED renderer reads the `paused` and `state` outputs.

Parameters:
N_BARS, 5, number of bars
H_W, 7, bits per bar height
IDX_W, 6, width of engine index cookie ({i,j}), stored and restored opaquely
DELAY, 100_000_000, clk cycles between automatic steps (must be >=2)
HIST_DEPTH, 16, snapshot entries (power of two)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; sort enabled (sw1); low forces IDLE
btn_run  in  1  one-cycle pulse; toggle run/pause
btn_next  in  1  one-cycle pulse; single step while paused
btn_prev  in  1  one-cycle pulse; undo one step while paused/done
heights_in  in  N_BARS*H_W  current bar heights, bar0 in LSBs
idx_in  in  IDX_W  current engine index cookie
engine_done  in  1  level; engine has finished sorting
step_req  out  1  request one compare/swap step
step_ack  in  1  engine completed step (one-cycle pulse)
restore_valid  out  1  one-cycle pulse; engine loads restore_*
restore_heights  out  N_BARS*H_W  snapshot heights
restore_idx  out  IDX_W  snapshot cookie
paused  out  1  high in PAUSED
state  out  3  current FSM state code
hist_count  out  $clog2(HIST_DEPTH)+1  valid snapshots held

Behaviour:
- Reset: state=IDLE, step_req=0, restore_valid=0, restore_*=0, paused=0, hist_count=0, timer=0, pause_pending=0.
- States: IDLE, RUN_WAIT, STEP_REQ, PAUSED, RESTORE, DONE.
- IDLE: start=1 -> RUN_WAIT, timer loaded with DELAY-1, history cleared.
- RUN_WAIT: timer decrements each cycle. The step is issued DELAY cycles after entering RUN_WAIT. At timer==0: push snapshot {heights_in,idx_in}, then go to STEP_REQ. If engine_done=1, go to DONE (no push). If btn_run=1, go to PAUSED.
- STEP_REQ: step_req=1, held until the step_ack cycle. step_req drops the cycle after ack. Next state is PAUSED if pause_pending or the step was a manual step; otherwise RUN_WAIT with the timer reloaded. A btn_run here toggles pause_pending; btn_next and btn_prev are ignored.
- PAUSED: btn_run -> RUN_WAIT with the timer reloaded. btn_next with engine_done=0 -> push snapshot, then STEP_REQ (manual). btn_prev with hist_count>0 -> RESTORE. btn_prev with hist_count==0 is ignored.
- RESTORE: lasts exactly 1 cycle. restore_valid=1 and restore_* come from registers holding the top entry. Pointer and count decrement. Then go to PAUSED.
- DONE: btn_prev with hist_count>0 -> RESTORE (ends in PAUSED). btn_run and btn_next are ignored.
- Simultaneous pulses: priority is btn_run > btn_prev > btn_next; lower-priority pulses are dropped.
- History is a circular LIFO. A push when full overwrites the oldest entry and hist_count saturates at HIST_DEPTH. Pointer wraps modulo HIST_DEPTH.
- start=0 in any state -> IDLE next cycle: step_req deasserts, history is cleared, and pause_pending is cleared. A pending ack is discarded.
- reset mid-handshake: all outputs return to reset values on the next edge.
- restore_* hold their last value outside RESTORE.

Decomposition:
- Package sort_viz_pkg holds:
  - state encoding: IDLE=0, RUN_WAIT=1, STEP_REQ=2, PAUSED=3, RESTORE=4, DONE=5
  - the N_BARS and H_W defaults
  - bar colour constants shared with the renderer
- Sub-module snapshot_stack: circular LIFO with push, pop, clear, top data, and count with saturation and overwrite-oldest.

Test Plan:
- DELAY=4, start rises at cycle 0 -> step_req high at cycle 5. Ack at cycle 7 -> RUN_WAIT, next step_req at cycle 12. hist_count=2 after the second push.
- Running, btn_run pulses during STEP_REQ -> after ack, state=PAUSED and paused=1. No further step_req for 20 cycles.
- PAUSED with heights {10,20,30,40,50}, idx=0x03, then btn_next, then ack, then btn_prev -> one restore_valid pulse with restore_heights={10,20,30,40,50}, restore_idx=0x03, hist_count back to 0.
- PAUSED, hist_count=0, btn_prev -> no restore_valid, state stays PAUSED. btn_prev and btn_next in the same cycle with hist_count=1 -> RESTORE taken, no step_req.
- 18 manual steps with HIST_DEPTH=16 -> hist_count=16. 16 btn_prev pulses return snapshots 18 down to 3 in LIFO order. A 17th btn_prev is ignored.
- start deasserted while step_req=1 -> step_req=0 and state=IDLE next cycle, hist_count=0. A late ack has no effect. A reset pulse in RUN_WAIT gives all outputs their reset values.

Source files
------------

// File: rtl/sort_viz_pkg.sv
// Shared types and constants for the bar-sort visualisation datapath.
// State codes here are also decoded by the OLED renderer.
package sort_viz_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_WAIT = 3'd1,
    STEP_REQ = 3'd2,
    PAUSED   = 3'd3,
    RESTORE  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int N_BARS_DEF = 5;
  localparam int H_W_DEF    = 7;

  // RGB565 bar colours used by the renderer
  localparam logic [15:0] COL_BG     = 16'h0000;
  localparam logic [15:0] COL_BAR    = 16'hFFFF;
  localparam logic [15:0] COL_ACTIVE = 16'hF800;
  localparam logic [15:0] COL_SORTED = 16'h07E0;

endpackage

// File: rtl/snapshot_stack.sv
// Circular LIFO of step snapshots; a push when full overwrites the oldest entry.
// Top entry is read combinationally; push/pop/clear take effect on the next edge, never stalls.
module snapshot_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 41
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            push_data,
  output logic [W-1:0]            top_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] top_ptr;

  // ptr is the next write slot, so the newest entry sits one below it
  assign top_ptr  = ptr - 1'b1;
  assign top_data = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= top_ptr;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/sort_step_controller.sv
// Run/pause sequencer pacing sort-engine steps, with snapshot history for undo.
// Steps issue DELAY cycles after entering RUN_WAIT; step_req holds until step_ack, restore_valid is a 1-cycle pulse.
module sort_step_controller
  import sort_viz_pkg::*;
#(
  parameter int N_BARS     = N_BARS_DEF,
  parameter int H_W        = H_W_DEF,
  parameter int IDX_W      = 6,
  parameter int DELAY      = 100_000_000,
  parameter int HIST_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          btn_run,
  input  logic                          btn_next,
  input  logic                          btn_prev,
  input  logic [N_BARS*H_W-1:0]         heights_in,
  input  logic [IDX_W-1:0]              idx_in,
  input  logic                          engine_done,
  output logic                          step_req,
  input  logic                          step_ack,
  output logic                          restore_valid,
  output logic [N_BARS*H_W-1:0]         restore_heights,
  output logic [IDX_W-1:0]              restore_idx,
  output logic                          paused,
  output logic [2:0]                    state,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);

  localparam int SW = N_BARS*H_W + IDX_W;
  localparam int TW = (DELAY > 2) ? $clog2(DELAY) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DELAY - 1);

  state_t        st;
  logic [TW-1:0] timer;
  logic          pause_pending;
  logic          manual;
  logic          timer_zero;
  logic          hist_clr;
  logic          hist_push;
  logic          hist_pop;
  logic [SW-1:0] top_data;

  assign state      = st;
  assign timer_zero = (timer == '0);

  // Stack strobes share their decode with the FSM so both agree on which button wins.
  always_comb begin
    hist_clr  = !start || st == IDLE;
    hist_push = 1'b0;
    hist_pop  = 1'b0;
    if (start) begin
      hist_push = (st == RUN_WAIT && !btn_run && timer_zero && !engine_done) ||
                  (st == PAUSED && !btn_run && !btn_prev && btn_next && !engine_done);
      hist_pop  = ((st == PAUSED && !btn_run) || st == DONE) && btn_prev &&
                  hist_count != '0;
    end
  end

  snapshot_stack #(
    .DEPTH (HIST_DEPTH),
    .W     (SW)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clear     (hist_clr),
    .push      (hist_push),
    .pop       (hist_pop),
    .push_data ({heights_in, idx_in}),
    .top_data  (top_data),
    .count     (hist_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= IDLE;
      step_req        <= 1'b0;
      restore_valid   <= 1'b0;
      restore_heights <= '0;
      restore_idx     <= '0;
      paused          <= 1'b0;
      timer           <= '0;
      pause_pending   <= 1'b0;
      manual          <= 1'b0;
    end else if (!start) begin
      // restore_* deliberately keep their last value here
      st            <= IDLE;
      step_req      <= 1'b0;
      restore_valid <= 1'b0;
      paused        <= 1'b0;
      pause_pending <= 1'b0;
      manual        <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st    <= RUN_WAIT;
          timer <= RELOAD;
        end
        RUN_WAIT: begin
          if (btn_run) begin
            st     <= PAUSED;
            paused <= 1'b1;
          end else if (timer_zero) begin
            if (engine_done) begin
              st <= DONE;
            end else begin
              st       <= STEP_REQ;
              step_req <= 1'b1;
              manual   <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STEP_REQ: begin
          if (step_ack) begin
            step_req      <= 1'b0;
            pause_pending <= 1'b0;
            if (manual || (pause_pending ^ btn_run)) begin
              st     <= PAUSED;
              paused <= 1'b1;
            end else begin
              st    <= RUN_WAIT;
              timer <= RELOAD;
            end
          end else if (btn_run) begin
            pause_pending <= !pause_pending;
          end
        end
        PAUSED: begin
          if (btn_run) begin
            st     <= RUN_WAIT;
            timer  <= RELOAD;
            paused <= 1'b0;
          end else if (hist_pop) begin
            st                           <= RESTORE;
            paused                       <= 1'b0;
            restore_valid                <= 1'b1;
            {restore_heights, restore_idx} <= top_data;
          end else if (hist_push) begin
            st       <= STEP_REQ;
            step_req <= 1'b1;
            manual   <= 1'b1;
            paused   <= 1'b0;
          end
        end
        RESTORE: begin
          st            <= PAUSED;
          paused        <= 1'b1;
          restore_valid <= 1'b0;
        end
        DONE: begin
          if (hist_pop) begin
            st                           <= RESTORE;
            restore_valid                <= 1'b1;
            {restore_heights, restore_idx} <= top_data;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_step_controller.sv
// Scoreboard bench: stimulus queues expected step/restore events, a negedge monitor pops and compares them.
module tb_sort_step_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [34:0] heights_in = '0;
  logic [5:0]  idx_in = '0;
  logic        engine_done = 1'b0;
  logic        step_req;
  logic        step_ack = 1'b0;
  logic        restore_valid;
  logic [34:0] restore_heights;
  logic [5:0]  restore_idx;
  logic        paused;
  logic [2:0]  state;
  logic [4:0]  hist_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prev_req = 1'b0;

  typedef struct {
    bit          is_restore;
    int          cyc;
    logic [34:0] h;
    logic [5:0]  idx;
    int          hc;
  } ev_t;
  ev_t exp_q[$];

  sort_step_controller #(
    .N_BARS(5), .H_W(7), .IDX_W(6), .DELAY(4), .HIST_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_run(btn_run),
    .btn_next(btn_next), .btn_prev(btn_prev), .heights_in(heights_in),
    .idx_in(idx_in), .engine_done(engine_done), .step_req(step_req),
    .step_ack(step_ack), .restore_valid(restore_valid),
    .restore_heights(restore_heights), .restore_idx(restore_idx),
    .paused(paused), .state(state), .hist_count(hist_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit r, input int c, input logic [34:0] h,
                           input logic [5:0] i, input int hc);
    ev_t e;
    e.is_restore = r; e.cyc = c; e.h = h; e.idx = i; e.hc = hc;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input bit is_rst);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event restore=%0d actual=event required=none (cycle %0d)", is_rst, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 64'(is_rst), 64'(e.is_restore));
    if (e.cyc >= 0) check("ev_cycle", 64'(cyc), 64'(e.cyc));
    check("ev_hist", 64'(hist_count), 64'(e.hc));
    if (is_rst) begin
      check("ev_heights", 64'(restore_heights), 64'(e.h));
      check("ev_idx", 64'(restore_idx), 64'(e.idx));
    end
  endtask

  always @(negedge clk) begin
    if (step_req === 1'b1 && !prev_req) check_event(1'b0);
    if (restore_valid === 1'b1) check_event(1'b1);
    prev_req = (step_req === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic p, input logic n);
    btn_run = r; btn_prev = p; btn_next = n;
    tick();
    btn_run = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
  endtask

  task automatic do_ack();
    int n = 0;
    while (step_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (step_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_wait actual=no step_req required=step_req within 100 cycles");
    end
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_step_req"}, 64'(step_req), 64'd0);
    check({tag, "_restore_valid"}, 64'(restore_valid), 64'd0);
    check({tag, "_restore_heights"}, 64'(restore_heights), 64'd0);
    check({tag, "_restore_idx"}, 64'(restore_idx), 64'd0);
    check({tag, "_paused"}, 64'(paused), 64'd0);
    check({tag, "_hist"}, 64'(hist_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    logic [34:0] h1, h2, hs, hb, hk;

    tick(); tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Automatic pacing with DELAY=4
    h1 = {7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
    h2 = {7'd9, 7'd8, 7'd7, 7'd6, 7'd11};
    heights_in = h1; idx_in = 6'd1;
    c0 = cyc;
    expect_ev(1'b0, c0 + 5, '0, '0, 1);
    expect_ev(1'b0, c0 + 12, '0, '0, 2);
    start = 1'b1;
    tick();
    check("run_wait_entry", 64'(state), 64'd1);
    while (cyc < c0 + 7) tick();
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    check("after_ack_state", 64'(state), 64'd1);
    check("after_ack_req", 64'(step_req), 64'd0);
    heights_in = h2; idx_in = 6'd2;
    n = 0;
    while (step_req !== 1'b1 && n < 50) begin tick(); n++; end
    check("second_req", 64'(step_req), 64'd1);

    // Pause requested mid-step
    press(1'b1, 1'b0, 1'b0);
    do_ack();
    check("pause_state", 64'(state), 64'd3);
    check("pause_flag", 64'(paused), 64'd1);
    for (int i = 0; i < 20; i++) tick();
    check("pause_no_step", 64'(step_req), 64'd0);
    check("pause_hist", 64'(hist_count), 64'd2);

    // Undo both automatic steps, newest first
    expect_ev(1'b1, -1, h2, 6'd2, 1);
    press(1'b0, 1'b1, 1'b0);
    tick();
    expect_ev(1'b1, -1, h1, 6'd1, 0);
    press(1'b0, 1'b1, 1'b0);
    tick();
    check("undo_state", 64'(state), 64'd3);
    check("undo_hist", 64'(hist_count), 64'd0);

    // Manual step then undo
    hs = {7'd50, 7'd40, 7'd30, 7'd20, 7'd10};
    heights_in = hs; idx_in = 6'h03;
    expect_ev(1'b0, -1, '0, '0, 1);
    press(1'b0, 1'b0, 1'b1);
    do_ack();
    check("manual_paused", 64'(state), 64'd3);
    heights_in = {7'd40, 7'd50, 7'd30, 7'd20, 7'd10};
    idx_in = 6'h04;
    expect_ev(1'b1, -1, hs, 6'h03, 0);
    press(1'b0, 1'b1, 1'b0);
    tick();
    check("manual_undo_hist", 64'(hist_count), 64'd0);
    check("manual_undo_idx_held", 64'(restore_idx), 64'h03);

    // Undo on empty history is ignored
    press(1'b0, 1'b1, 1'b0);
    check("empty_prev_state", 64'(state), 64'd3);
    check("empty_prev_valid", 64'(restore_valid), 64'd0);

    // prev beats next in the same cycle
    hb = {7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
    heights_in = hb; idx_in = 6'd5;
    expect_ev(1'b0, -1, '0, '0, 1);
    press(1'b0, 1'b0, 1'b1);
    do_ack();
    expect_ev(1'b1, -1, hb, 6'd5, 0);
    press(1'b0, 1'b1, 1'b1);
    check("prio_state", 64'(state), 64'd4);
    check("prio_no_req", 64'(step_req), 64'd0);
    tick();
    check("prio_back_paused", 64'(state), 64'd3);

    // Overflow: 18 manual steps into 16 slots
    for (int k = 1; k <= 18; k++) begin
      hk = {5{7'(k)}};
      heights_in = hk; idx_in = 6'(k);
      expect_ev(1'b0, -1, '0, '0, (k > 16) ? 16 : k);
      press(1'b0, 1'b0, 1'b1);
      do_ack();
    end
    check("full_hist", 64'(hist_count), 64'd16);
    for (int k = 18; k >= 3; k--) begin
      hk = {5{7'(k)}};
      expect_ev(1'b1, -1, hk, 6'(k), k - 3);
      press(1'b0, 1'b1, 1'b0);
      tick();
    end
    press(1'b0, 1'b1, 1'b0);
    check("drained_prev_valid", 64'(restore_valid), 64'd0);
    check("drained_state", 64'(state), 64'd3);
    check("drained_hist", 64'(hist_count), 64'd0);

    // start dropped mid-handshake
    heights_in = {7'd7, 7'd7, 7'd7, 7'd7, 7'd7}; idx_in = 6'd7;
    expect_ev(1'b0, -1, '0, '0, 1);
    press(1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check("abort_req", 64'(step_req), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_hist", 64'(hist_count), 64'd0);
    check("abort_paused", 64'(paused), 64'd0);
    check("abort_restore_held", 64'(restore_idx), 64'd3);
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    check("late_ack_idle", 64'(state), 64'd0);
    start = 1'b1;
    tick();
    check("restart_state", 64'(state), 64'd1);
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    check("stray_ack_state", 64'(state), 64'd1);
    check("stray_ack_req", 64'(step_req), 64'd0);

    // Reset while running
    reset = 1'b1;
    start = 1'b0;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;

    // Engine already done: timer expiry goes to DONE without a snapshot
    engine_done = 1'b1;
    c0 = cyc;
    start = 1'b1;
    while (cyc < c0 + 6) tick();
    check("done_state", 64'(state), 64'd5);
    check("done_hist", 64'(hist_count), 64'd0);
    press(1'b1, 1'b0, 1'b1);
    check("done_ignores_run", 64'(state), 64'd5);
    check("done_no_req", 64'(step_req), 64'd0);

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
